fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core. Holds the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready interface. It presents each returned instruction with its PC to decode over a valid/ready handshake. It consumes the execute-stage redirect, formed from `branch_taken` or a jump, and flushes any stale in-flight instruction when a redirect arrives.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; bits [1:0] must be 0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: fetch address; equals the current PC.
- `imem_rsp_valid` in 1: response valid, one per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `if_valid` out 1: instruction available to decode.
- `if_ready` in 1: decode accepts the instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_instr` out 32: presented instruction.
- `redirect_valid` in 1: taken branch or jump from execute.
- `redirect_target` in 32: new PC.
- `fetch_misaligned` out 1: misaligned-target trap flag; see Configuration.

## Operation
- FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT, S_DROP, S_TRAP.
- S_IDLE: entered on reset; goes unconditionally to S_REQ the next cycle.
- S_REQ: `imem_req_valid`=1 and `imem_req_addr`=pc. On `imem_req_ready`, go to S_WAIT.
- S_WAIT: on `imem_rsp_valid`, register `if_instr`←data and `if_pc`←pc, set pc←pc+4 (mod 2^32; wraps from 0xFFFF_FFFC to 0), then go to S_OUT.
- S_OUT: `if_valid`=1. On `if_ready`, go to S_REQ.
- S_DROP: wait for the stale response, discard it, then go to S_REQ.
- A redirect has priority over every other transition. In all cases pc←`redirect_target`. The next state depends on the current state:
  - S_REQ without handshake: stay in S_REQ. The address may change while valid is unaccepted, which is permitted.
  - S_REQ with handshake in the same cycle: go to S_DROP, because the accepted request's response must be discarded.
  - S_WAIT with no response this cycle: go to S_DROP.
  - S_WAIT with a response in the same cycle: discard the response and go to S_REQ.
  - S_OUT: discard the held instruction and go to S_REQ, even if `if_ready` is high. The decode handshake in that cycle does not count.
  - S_DROP: stay in S_DROP with the pc updated.
  - S_IDLE: go to S_REQ.
- At most one request is outstanding. A response outside S_WAIT/S_DROP is a protocol violation and is ignored.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=0, `fetch_misaligned`=0, state=S_IDLE.
- The first request is asserted the 1st cycle after `rst_n` is sampled high.
- Latency: `if_valid` rises 1 cycle after the `imem_rsp_valid` cycle.
- Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, OUT) with zero-wait memory.
- Redirect:
  - `if_valid` is 0 in the cycle after `redirect_valid`.
  - The new target is requested no earlier than that cycle.
  - No instruction fetched before the redirect ever reaches decode.
- `if_valid`, `if_pc` and `if_instr` are stable while `if_valid`=1 and `if_ready`=0.
- Reset mid-operation returns to S_IDLE on the next edge. Any outstanding response that arrives after reset is ignored because S_IDLE/S_REQ discard it.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_target[1:0]`≠0 loads pc and enters S_TRAP.
  - In S_TRAP, `fetch_misaligned`=1 (sticky), no requests are issued, responses are ignored, and `if_valid`=0.
  - Only reset leaves S_TRAP.
- Undefined:
  - `redirect_target[1:0]` is forced to 2'b00.
  - S_TRAP is unreachable and `fetch_misaligned` is tied to 0.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, `if_ready`=1 → PCs 0x100, 0x104, 0x108 are presented, each with the matching instruction, one every 3 cycles.
- `if_ready` held 0 for 5 cycles while `if_valid`=1 → `if_pc`/`if_instr` are unchanged and no new `imem_req_valid` is issued.
- Redirect to 0x200 in S_WAIT, response 2 cycles later → the stale word is dropped, the next request address is 0x200, and 0x200 is the next `if_pc`.
- Redirect to 0x40 in S_OUT with `if_ready`=1 in the same cycle → the held instruction is not consumed and the next `if_pc` is 0x40.
- PC 0xFFFF_FFFC fetched → the next request address is 0x0000_0000.
- With the macro, a redirect to 0x202 → `fetch_misaligned`=1, no further requests, and reset clears it. Without the macro, the same redirect fetches 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage
//
// Holds the program counter. Issues one word-aligned request at a time to
// instruction memory and presents each returned word, with its PC, to decode.
// An execute-stage redirect reloads the PC. Any request already in flight
// when the redirect arrives has its response discarded.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a target with bits [1:0] != 0 enters a sticky
//               trap state. The trap raises fetch_misaligned and stops
//               fetching until reset.
//   undefined : redirect_target[1:0] is forced to 0 and fetch_misaligned = 0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req_*          request channel to instruction memory (valid/ready)
//   imem_rsp_*          response channel (one response per accepted request)
//   if_valid/if_ready   handshake to decode; if_pc / if_instr are the payload
//   redirect_valid      taken branch / jump from execute
//   redirect_target     new PC
//   fetch_misaligned    misaligned-target trap flag
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DROP,
        S_TRAP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic        req_valid_reg;
    logic        if_valid_reg;

    logic [31:0] target;
    logic        target_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target     = redirect_target;
    assign target_bad = |redirect_target[1:0];
`else
    // Low bits are discarded so every fetch stays word aligned.
    logic unused_target_low;
    assign unused_target_low = ^redirect_target[1:0];
    assign target     = {redirect_target[31:2], 2'b00};
    assign target_bad = 1'b0;
`endif

    // Next-state logic. A redirect overrides every normal transition
    // except in the trap state, which only reset can leave.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        if_pc_next    = if_pc_reg;
        if_instr_next = if_instr_reg;

        if (redirect_valid && state_reg != S_TRAP) begin
            pc_next = target;
            if (target_bad) begin
                state_next = S_TRAP;
            end else begin
                case (state_reg)
                    // An accepted request must have its response dropped.
                    S_REQ:   state_next = imem_req_ready ? S_DROP : S_REQ;
                    // A response in the same cycle is consumed and thrown away.
                    S_WAIT:  state_next = imem_rsp_valid ? S_REQ : S_DROP;
                    S_DROP:  state_next = S_DROP;
                    // S_IDLE and S_OUT refetch immediately. The held
                    // instruction is abandoned even if decode is ready.
                    default: state_next = S_REQ;
                endcase
            end
        end else begin
            case (state_reg)
                S_IDLE: state_next = S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if_instr_next = imem_rsp_data;
                        if_pc_next    = pc_reg;
                        pc_next       = pc_reg + 32'd4;
                        state_next    = S_OUT;
                    end
                end
                S_OUT: begin
                    if (if_ready) begin
                        state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state_next = S_REQ;
                    end
                end
                S_TRAP:  state_next = S_TRAP;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs are registered from the next state, so they are
    // glitch-free and line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            pc_reg        <= RESET_PC;
            if_pc_reg     <= 32'h0;
            if_instr_reg  <= 32'h0;
            req_valid_reg <= 1'b0;
            if_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            if_pc_reg     <= if_pc_next;
            if_instr_reg  <= if_instr_next;
            req_valid_reg <= (state_next == S_REQ);
            if_valid_reg  <= (state_next == S_OUT);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_reg <= 1'b0;
        end else if (state_next == S_TRAP) begin
            misaligned_reg <= 1'b1;
        end
    end

    assign fetch_misaligned = misaligned_reg;
`else
    assign fetch_misaligned = 1'b0;
`endif

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = pc_reg;
    assign if_valid       = if_valid_reg;
    assign if_pc          = if_pc_reg;
    assign if_instr       = if_instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit (RESET_PC = 0x100).
// A small memory model answers each accepted request after rsp_delay cycles
// with instr_of(addr). Per-cycle expectations come from a vector table for
// the streaming and stall phase. Hand-written sequences cover redirects,
// PC wrap-around, misaligned targets and reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // ---------------- memory model ----------------
    int          rsp_delay = 1;
    logic        mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_addr  = 32'h0;
    logic        mem_hs;
    logic [31:0] mem_req_a;

    always @(posedge clk) begin
        mem_hs    = imem_req_valid && imem_req_ready;
        mem_req_a = imem_req_addr;
        #1;
        imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            mem_pend = 1'b0;
        end else begin
            if (mem_hs) begin
                mem_pend = 1'b1;
                mem_addr = mem_req_a;
                mem_cnt  = rsp_delay;
            end
            if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = instr_of(mem_addr);
                    mem_pend       = 1'b0;
                end else begin
                    mem_cnt = mem_cnt - 1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Check one cycle at the falling edge, then advance to just after the
    // next rising edge.
    task automatic cyc(input string tag, input logic rv, input logic [31:0] ra,
                       input logic iv, input logic [31:0] ip, input logic em);
        @(negedge clk);
        chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, rv});
        chk({tag, ".req_addr"}, imem_req_addr, ra);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, iv});
        chk({tag, ".if_pc"}, if_pc, ip);
        chk({tag, ".misaligned"}, {31'b0, fetch_misaligned}, {31'b0, em});
        if (iv) chk({tag, ".if_instr"}, if_instr, instr_of(ip));
        $display("cycle %-10s req=%0b addr=%h if_valid=%0b if_pc=%h instr=%h mis=%0b",
                 tag, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misaligned);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        if_ready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Cycles C1..C14 after reset release, zero-wait memory.
        vecs[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
        vecs[1]  = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h000};
        vecs[2]  = '{1'b1, 1'b0, 32'h104, 1'b1, 32'h100};
        vecs[3]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h100};
        vecs[4]  = '{1'b1, 1'b0, 32'h104, 1'b0, 32'h100};
        vecs[5]  = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h104};  // stall 5 cycles
        vecs[6]  = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h104};
        vecs[7]  = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h104};
        vecs[8]  = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h104};
        vecs[9]  = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h104};
        vecs[10] = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
        vecs[11] = '{1'b1, 1'b1, 32'h108, 1'b0, 32'h104};
        vecs[12] = '{1'b1, 1'b0, 32'h108, 1'b0, 32'h104};
        vecs[13] = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h108};

        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        cyc("reset", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        // The edge at the end of this wait samples rst_n high (IDLE -> REQ).
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if_ready = vecs[i].if_ready;
            cyc(tag, vecs[i].exp_rv, vecs[i].exp_addr, vecs[i].exp_iv, vecs[i].exp_pc, 1'b0);
        end

        // Redirect to 0x200 while waiting; the stale response arrives 2 cycles later.
        rsp_delay = 3;
        cyc("req10c", 1'b1, 32'h10C, 1'b0, 32'h108, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        cyc("wait_rd", 1'b0, 32'h10C, 1'b0, 32'h108, 1'b0);
        redirect_valid = 1'b0;
        rsp_delay      = 1;
        cyc("drop1", 1'b0, 32'h200, 1'b0, 32'h108, 1'b0);
        cyc("drop2", 1'b0, 32'h200, 1'b0, 32'h108, 1'b0);
        cyc("req200", 1'b1, 32'h200, 1'b0, 32'h108, 1'b0);
        cyc("wait200", 1'b0, 32'h200, 1'b0, 32'h108, 1'b0);

        // Redirect to 0x40 in OUT with if_ready high in the same cycle.
        if_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        cyc("out200", 1'b0, 32'h204, 1'b1, 32'h200, 1'b0);
        redirect_valid = 1'b0;
        cyc("req40", 1'b1, 32'h40, 1'b0, 32'h200, 1'b0);
        if_ready = 1'b0;
        cyc("wait40", 1'b0, 32'h40, 1'b0, 32'h200, 1'b0);

        // Redirect to the last word and check the PC wraps to 0.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cyc("out40", 1'b0, 32'h44, 1'b1, 32'h40, 1'b0);
        redirect_valid = 1'b0;
        cyc("reqtop", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b0);
        if_ready = 1'b1;
        cyc("waittop", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b0);
        cyc("outtop", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);

        // Misaligned redirect while a request is pending (memory not ready).
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        cyc("req0", 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        cyc("trap0", 1'b0, 32'h202, 1'b0, 32'hFFFF_FFFC, 1'b1);
        for (int i = 1; i < 6; i++) begin
            // A later redirect must not release the trap.
            redirect_valid  = (i == 2);
            redirect_target = 32'h300;
            cyc($sformatf("trap%0d", i), 1'b0, 32'h202, 1'b0, 32'hFFFF_FFFC, 1'b1);
        end
        redirect_valid = 1'b0;
`else
        cyc("req200b", 1'b1, 32'h200, 1'b0, 32'hFFFF_FFFC, 1'b0);
        cyc("wait200b", 1'b0, 32'h200, 1'b0, 32'hFFFF_FFFC, 1'b0);
        cyc("out200b", 1'b0, 32'h204, 1'b1, 32'h200, 1'b0);
`endif

        // Reset mid-operation clears everything, including the trap flag.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst2", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst2req", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
